uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 86 ++++++++
 tb/tb_uart_tx_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one serial transmitter between 4 byte requesters, with lock for messages.
// Latency: req seen in IDLE -> tx_start two cycles later; locked streams leave 2 idle cycles after each ack.
// Backpressure: holds in SEND until tx_ready, and in DONE until the transmitter goes idle again.
module uart_tx_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [31:0] din,
    output logic [3:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        BUSY = 3'd3,
        DONE = 3'd4,
        NEXT = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last_ptr;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       grant_vld;

    // Search starts one past the last grant, so k=4 wraps back onto last_ptr itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_ptr;
        cand      = last_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + k[1:0];
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_vld) state_nxt = LOAD;
            LOAD: state_nxt = SEND;
            SEND: if (tx_ready) state_nxt = BUSY;
            BUSY: if (!tx_ready) state_nxt = DONE;
            DONE: if (tx_ready) state_nxt = NEXT;
            NEXT: state_nxt = (req[owner] && lock[owner]) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack = 4'b0000;
        if (state == DONE && tx_ready) ack[owner] = 1'b1;
    end

    assign tx_start = (state == SEND) && tx_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last_ptr <= 2'd3;
            tx_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                owner    <= grant_idx;
                last_ptr <= grant_idx;
            end
            // Byte is captured once here; later din/req changes cannot alter it.
            if (state == LOAD) tx_data <= din[{owner, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a transmitter model that goes busy for 10 cycles per byte.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] din;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready;

    logic [3:0]  low_cnt = 4'd0;
    logic        force_low = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_tx_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .din      (din),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Transmitter: accepts on tx_start, stays busy for the following 10 cycles.
    always @(posedge clk) begin
        if (tx_start && tx_ready) low_cnt <= 4'd10;
        else if (low_cnt != 4'd0) low_cnt <= low_cnt - 4'd1;
    end
    assign tx_ready = (low_cnt == 4'd0) && !force_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 200);
        chk({tag, "_start_seen"}, tx_start, 1'b1);
    endtask

    task automatic wait_ack(input string tag, output int n, output logic [3:0] a);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == 4'b0000 && n < 200);
        a = ack;
        chk({tag, "_ack_seen"}, (ack != 4'b0000), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [3:0]  a;
        int          starts;
        logic [7:0]  msg [4];
        logic [1:0]  exp_own [5];

        msg     = '{8'h48, 8'h6F, 8'h6C, 8'h61};
        exp_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b1; req = 4'h0; lock = 4'h0; din = 32'h0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 4'h0);
        chk("rst_start", tx_start, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_data", tx_data, 8'h00);

        // Single byte from requester 0
        rst = 1'b0; req = 4'b0001; din[7:0] = 8'h48;
        tick();
        chk("b1_load_start", tx_start, 1'b0);
        chk("b1_load_busy", busy, 1'b1);
        tick();
        chk("b1_start_c2", tx_start, 1'b1);
        chk("b1_data", tx_data, 8'h48);
        chk("b1_owner", owner, 2'd0);
        req = 4'b0000;
        wait_ack("b1", n, a);
        chk("b1_ack", a, 4'b0001);
        chk("b1_ack_lat", n, 11);
        tick();
        chk("b1_ack_once", ack, 4'h0);
        chk("b1_next_busy", busy, 1'b1);
        tick();
        chk("b1_idle", busy, 1'b0);

        // All requesting, no lock: rotation from reset pointer
        rst = 1'b1; tick(); rst = 1'b0;
        din = 32'hD3C2_B1A0; req = 4'b1111; lock = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            wait_start("rr", n);
            chk("rr_owner", owner, exp_own[i]);
            chk("rr_data", tx_data, din[{exp_own[i], 3'b000} +: 8]);
            wait_ack("rr", n, a);
            chk("rr_ack", a, 4'b0001 << exp_own[i]);
            if (i == 4) req = 4'b0000;
        end
        tick(); tick();
        chk("rr_idle", busy, 1'b0);

        // Locked message "Hola" from 2 while 0 waits; pointer is 0 so 2 wins
        din = 32'h0000_005A; din[23:16] = msg[0];
        req = 4'b0101; lock = 4'b0100;
        wait_start("msg", n);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                wait_start("msg", n);
                chk("msg_gap", n, 2);
            end
            chk("msg_owner", owner, 2'd2);
            chk("msg_data", tx_data, msg[i]);
            wait_ack("msg", n, a);
            chk("msg_ack", a, 4'b0100);
            if (i == 3) begin req = 4'b0001; lock = 4'b0000; end
            tick();
            chk("msg_next_owner", owner, 2'd2);
            if (i < 3) din[23:16] = msg[i + 1];
        end
        wait_start("after_msg", n);
        chk("after_msg_lat", n, 3);
        chk("after_msg_owner", owner, 2'd0);
        chk("after_msg_data", tx_data, 8'h5A);
        req = 4'b0000;
        wait_ack("after_msg", n, a);
        chk("after_msg_ack", a, 4'b0001);
        tick(); tick();
        chk("after_msg_idle", busy, 1'b0);

        // Transmitter not ready at grant; then req[1] dropped in BUSY
        force_low = 1'b1; din[15:8] = 8'hC7; req = 4'b0010;
        tick(); tick();
        chk("stall_owner", owner, 2'd1);
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start) starts++;
            tick();
        end
        chk("stall_no_start", starts, 0);
        chk("stall_busy", busy, 1'b1);
        force_low = 1'b0;
        #1;
        chk("stall_release_start", tx_start, 1'b1);
        chk("stall_data", tx_data, 8'hC7);
        tick();
        chk("stall_single_start", tx_start, 1'b0);
        req = 4'b0000;
        wait_ack("drop", n, a);
        chk("drop_ack", a, 4'b0010);
        chk("drop_ack_lat", n, 10);
        tick();
        chk("drop_next_busy", busy, 1'b1);
        tick();
        chk("drop_idle", busy, 1'b0);

        // Reset in BUSY, then requester 3 wins from pointer 3
        req = 4'b0100; din[23:16] = 8'hE4;
        wait_start("rb", n);
        chk("rb_owner", owner, 2'd2);
        tick();
        chk("rb_in_busy", busy, 1'b1);
        rst = 1'b1; req = 4'b0000;
        tick();
        chk("rb_busy", busy, 1'b0);
        chk("rb_ack", ack, 4'h0);
        chk("rb_start", tx_start, 1'b0);
        chk("rb_owner0", owner, 2'd0);
        rst = 1'b0; req = 4'b1000; din[31:24] = 8'h3E;
        tick();
        chk("rb_grant3", owner, 2'd3);
        wait_start("rb3", n);
        chk("rb3_data", tx_data, 8'h3E);
        req = 4'b0000;
        wait_ack("rb3", n, a);
        chk("rb3_ack", a, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
